// File: rtl/ser2par_pkg.sv
// Shared types and helpers for the ser_2_par_deser serial-to-parallel deserializer.
// Optional parity framing is enabled by defining SER2PAR_PARITY_CHECK_EN.
package ser2par_pkg;

   // Framing state: COLLECT gathers data bits, PARITY waits for the trailing parity bit
   typedef enum logic {
      COLLECT = 1'b0,
      PARITY  = 1'b1
   } ser2par_state_e;

   // Width of a counter able to hold the values 0..w
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

   // Set when frames carry a trailing even-parity bit
`ifdef SER2PAR_PARITY_CHECK_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   // Total serial bits per frame for a given data width
   function automatic int frame_len(input int w);
      return w + int'(PARITY_EN);
   endfunction

endpackage

// File: rtl/ser2par_out_reg.sv
// Valid/ready output holding stage for ser_2_par_deser.
// Accepts a completed word when the slot is free, otherwise drops it and pulses overflow.
module ser2par_out_reg #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] word,
   input  logic                  perr,
   input  logic                  ready,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic                  parity_err,
   output logic                  overflow
);

   logic slot_free;

   // Slot can take a new word if empty or being drained on this same edge
   always_comb begin
      slot_free = !dout_valid || ready;
   end

   // Hold the word until consumed; a word arriving into a busy slot is lost
   always_ff @(posedge clk) begin
      if (reset) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         parity_err <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         overflow <= 1'b0;
         if (load) begin
            if (slot_free) begin
               dout       <= word;
               dout_valid <= 1'b1;
               parity_err <= perr;
            end else begin
               overflow <= 1'b1;
            end
         end else if (dout_valid && ready) begin
            dout_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ser_2_par_deser.sv
// Serial-to-parallel deserializer with bit-valid qualifier, counter framing,
// selectable bit order and a valid/ready output stage with overflow reporting.
// Define SER2PAR_PARITY_CHECK_EN to append an even-parity bit to every frame.
module ser_2_par_deser
   import ser2par_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter bit          MSB_FIRST  = 1'b1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 clear,
   input  logic                                 din,
   input  logic                                 din_valid,
   output logic [DATA_WIDTH-1:0]                dout,
   output logic                                 dout_valid,
   input  logic                                 dout_ready,
   output logic                                 overflow,
   output logic                                 parity_err,
   output logic [cnt_width(DATA_WIDTH)-1:0]     bit_cnt
);

   localparam int unsigned CW = cnt_width(DATA_WIDTH);

   ser2par_state_e        state, state_next;
   logic [DATA_WIDTH-1:0] sreg, sreg_next, shifted, word;
   logic [CW-1:0]         cnt, cnt_next;
   logic                  load, perr;

   // Next shift register contents with the incoming bit inserted at the first-bit end
   always_comb begin
      if (MSB_FIRST) begin
         shifted = {sreg[DATA_WIDTH-2:0], din};
      end else begin
         shifted = {din, sreg[DATA_WIDTH-1:1]};
      end
   end

   // Framing: count valid bits, detect the completion edge and hand the word out
   always_comb begin
      state_next = state;
      sreg_next  = sreg;
      cnt_next   = cnt;
      load       = 1'b0;
      word       = shifted;
      perr       = 1'b0;
      if (clear) begin
         state_next = COLLECT;
         sreg_next  = '0;
         cnt_next   = '0;
      end else if (din_valid) begin
         case (state)
            COLLECT: begin
               sreg_next = shifted;
               if (cnt == CW'(DATA_WIDTH - 1)) begin
`ifdef SER2PAR_PARITY_CHECK_EN
                  state_next = PARITY;
                  cnt_next   = cnt + CW'(1);
`else
                  load     = 1'b1;
                  cnt_next = '0;
`endif
               end else begin
                  cnt_next = cnt + CW'(1);
               end
            end
            PARITY: begin
               // Parity bit is checked but never stored in the word
               load       = 1'b1;
               word       = sreg;
               perr       = (^sreg) ^ din;
               cnt_next   = '0;
               state_next = COLLECT;
            end
            default: begin
               state_next = COLLECT;
               cnt_next   = '0;
            end
         endcase
      end
   end

   // State, shift register and bit counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= COLLECT;
         sreg  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_next;
         sreg  <= sreg_next;
         cnt   <= cnt_next;
      end
   end

   // Visible bit count is the registered counter
   always_comb begin
      bit_cnt = cnt;
   end

   ser2par_out_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_reg (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .word       (word),
      .perr       (perr),
      .ready      (dout_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .parity_err (parity_err),
      .overflow   (overflow)
   );

endmodule

// File: tb/tb_ser_2_par_deser.sv
// Self-checking bench for ser_2_par_deser: MSB-first and LSB-first instances share stimulus
// and are compared every cycle against a bit-queue model of the framing rules.
module tb_ser_2_par_deser;

   localparam int unsigned DW = 4;
   localparam int unsigned CW = $clog2(DW + 1);
`ifdef SER2PAR_PARITY_CHECK_EN
   localparam int unsigned FRAME = DW + 1;
`else
   localparam int unsigned FRAME = DW;
`endif
   localparam int unsigned OW = 2 * DW + 6 + 2 * CW;

   logic clk = 1'b0;
   logic reset, clear, din, din_valid, dout_ready;
   logic [DW-1:0] dout_m, dout_l;
   logic dv_m, dv_l, ovf_m, ovf_l, pe_m, pe_l;
   logic [CW-1:0] cnt_m, cnt_l;

   // Reference model
   bit            q[$];
   logic [DW-1:0] e_dout_m, e_dout_l;
   logic          e_valid, e_ovf, e_perr;
   int            n_tests, n_fail;

   always #5 clk = ~clk;

   ser_2_par_deser #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset), .clear(clear), .din(din), .din_valid(din_valid),
      .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready), .overflow(ovf_m),
      .parity_err(pe_m), .bit_cnt(cnt_m));

   ser_2_par_deser #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .clear(clear), .din(din), .din_valid(din_valid),
      .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready), .overflow(ovf_l),
      .parity_err(pe_l), .bit_cnt(cnt_l));

   function automatic logic [OW-1:0] obs();
      return {dout_m, dout_l, dv_m, dv_l, ovf_m, ovf_l, pe_m, pe_l, cnt_m, cnt_l};
   endfunction

   function automatic logic [OW-1:0] expv();
      return {e_dout_m, e_dout_l, e_valid, e_valid, e_ovf, e_ovf, e_perr, e_perr,
              CW'(q.size()), CW'(q.size())};
   endfunction

   // Serial frame for a data word, first transmitted bit in the MSB position
   function automatic logic [FRAME-1:0] frame_of(input logic [DW-1:0] w);
`ifdef SER2PAR_PARITY_CHECK_EN
      return {w, ^w};
`else
      return w;
`endif
   endfunction

   // Drive one clock of inputs and advance the model to what must be visible after the edge
   task automatic step(input logic rst, input logic clr, input logic dv, input logic d,
                       input logic rdy);
      bit complete;
      bit par;
      reset = rst; clear = clr; din_valid = dv; din = d; dout_ready = rdy;
      e_ovf = 1'b0;
      complete = 1'b0;
      if (rst) begin
         q.delete();
         e_dout_m = '0; e_dout_l = '0; e_valid = 1'b0; e_perr = 1'b0;
      end else begin
         if (clr) begin
            q.delete();
         end else if (dv) begin
            q.push_back(d);
            if (q.size() == int'(FRAME)) begin
               complete = 1'b1;
               par = 1'b0;
               foreach (q[i]) par ^= q[i];
               if (!e_valid || rdy) begin
                  for (int i = 0; i < int'(DW); i++) begin
                     e_dout_m[int'(DW) - 1 - i] = q[i];
                     e_dout_l[i] = q[i];
                  end
                  e_perr = (FRAME > DW) ? par : 1'b0;
                  e_valid = 1'b1;
               end else begin
                  e_ovf = 1'b1;
               end
               q.delete();
            end
         end
         if (!complete && e_valid && rdy) e_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (obs() !== '0) begin
         n_fail++;
         $display("FAIL reset_values got=%h want=%h", obs(), {OW{1'b0}});
      end
   endtask

   task automatic test_bit_order();
      logic [FRAME-1:0] f;
      f = frame_of(4'b1011);
      for (int i = int'(FRAME) - 1; i >= 0; i--) begin
         step(1'b0, 1'b0, 1'b1, f[i], 1'b1);
         n_tests++;
         if (obs() !== expv()) begin
            n_fail++; $display("FAIL order_step got=%h want=%h", obs(), expv());
         end
      end
      n_tests++;
      if ({dout_m, dout_l, dv_m, dv_l} !== {4'b1011, 4'b1101, 2'b11}) begin
         n_fail++; $display("FAIL order_word got=%h want=%h", {dout_m, dout_l, dv_m, dv_l}, {4'b1011, 4'b1101, 2'b11});
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_tests++;
      if ({dv_m, dv_l} !== 2'b00) begin
         n_fail++; $display("FAIL order_valid_one_cycle got=%b want=00", {dv_m, dv_l});
      end
      // Same word with three idle cycles after every bit
      for (int i = int'(FRAME) - 1; i >= 0; i--) begin
         step(1'b0, 1'b0, 1'b1, f[i], 1'b1);
         for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b0, 1'b0, ~f[i], 1'b1);
            n_tests++;
            if (obs() !== expv()) begin
               n_fail++; $display("FAIL gap_step got=%h want=%h", obs(), expv());
            end
         end
      end
      n_tests++;
      if ({dout_m, dout_l} !== {4'b1011, 4'b1101}) begin
         n_fail++; $display("FAIL gap_word got=%h want=%h", {dout_m, dout_l}, {4'b1011, 4'b1101});
      end
   endtask

   task automatic test_overflow();
      logic [2*FRAME-1:0] f;
      f = {frame_of(4'b1011), frame_of(4'b0110)};
      for (int i = 2 * int'(FRAME) - 1; i >= 0; i--) begin
         step(1'b0, 1'b0, 1'b1, f[i], 1'b0);
         n_tests++;
         if (obs() !== expv()) begin
            n_fail++; $display("FAIL ovf_step got=%h want=%h", obs(), expv());
         end
      end
      n_tests++;
      if ({ovf_m, dout_m, dv_m} !== {1'b1, 4'b1011, 1'b1}) begin
         n_fail++; $display("FAIL ovf_pulse got=%h want=%h", {ovf_m, dout_m, dv_m}, {1'b1, 4'b1011, 1'b1});
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if ({ovf_m, ovf_l, dv_m} !== 3'b001) begin
         n_fail++; $display("FAIL ovf_one_cycle got=%b want=001", {ovf_m, ovf_l, dv_m});
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_tests++;
      if ({dv_m, dv_l, dout_m} !== {2'b00, 4'b1011}) begin
         n_fail++; $display("FAIL ovf_drain got=%h want=%h", {dv_m, dv_l, dout_m}, {2'b00, 4'b1011});
      end
   endtask

   task automatic test_clear_reset();
      logic [FRAME-1:0] f;
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      n_tests++;
      if (obs() !== expv() || cnt_m !== CW'(0)) begin
         n_fail++; $display("FAIL clear_flush got=%h want=%h", obs(), expv());
      end
      f = frame_of(4'b0011);
      for (int i = int'(FRAME) - 1; i >= 0; i--) step(1'b0, 1'b0, 1'b1, f[i], 1'b1);
      n_tests++;
      if ({dout_m, dv_m} !== {4'b0011, 1'b1}) begin
         n_fail++; $display("FAIL clear_word got=%h want=%h", {dout_m, dv_m}, {4'b0011, 1'b1});
      end
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      n_tests++;
      if (obs() !== '0) begin
         n_fail++; $display("FAIL reset_midword got=%h want=0", obs());
      end
      f = frame_of(4'b1001);
      for (int i = int'(FRAME) - 1; i >= 0; i--) step(1'b0, 1'b0, 1'b1, f[i], 1'b0);
      n_tests++;
      if ({dout_m, dout_l, dv_m} !== {4'b1001, 4'b1001, 1'b1}) begin
         n_fail++; $display("FAIL reset_fresh_word got=%h want=%h", {dout_m, dout_l, dv_m}, {4'b1001, 4'b1001, 1'b1});
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      logic [FRAME-1:0] f;
      int words, ovfs;
      words = 0; ovfs = 0;
      for (int w = 0; w < 4; w++) begin
         f = frame_of(DW'($urandom));
         for (int i = int'(FRAME) - 1; i >= 0; i--) begin
            step(1'b0, 1'b0, 1'b1, f[i], 1'b1);
            if (dv_m) words++;
            if (ovf_m) ovfs++;
            n_tests++;
            if (obs() !== expv()) begin
               n_fail++; $display("FAIL b2b_step got=%h want=%h", obs(), expv());
            end
         end
      end
      n_tests++;
      if (words !== 4 || ovfs !== 0) begin
         n_fail++; $display("FAIL b2b_count words=%0d ovf=%0d want 4/0", words, ovfs);
      end
   endtask

   task automatic test_parity();
      logic [DW-1:0] w;
      w = 4'b1011;
`ifdef SER2PAR_PARITY_CHECK_EN
      for (int p = 1; p >= 0; p--) begin
         for (int i = int'(DW) - 1; i >= 0; i--) step(1'b0, 1'b0, 1'b1, w[i], 1'b1);
         step(1'b0, 1'b0, 1'b1, p[0], 1'b1);
         n_tests++;
         if ({dout_m, pe_m, pe_l} !== {4'b1011, ~p[0], ~p[0]}) begin
            n_fail++; $display("FAIL parity_bit%0d got=%h want=%h", p, {dout_m, pe_m, pe_l}, {4'b1011, ~p[0], ~p[0]});
         end
      end
`else
      for (int i = int'(DW) - 1; i >= 0; i--) step(1'b0, 1'b0, 1'b1, w[i], 1'b1);
      n_tests++;
      if ({dout_m, pe_m, pe_l} !== {4'b1011, 2'b00}) begin
         n_fail++; $display("FAIL parity_tied got=%h want=%h", {dout_m, pe_m, pe_l}, {4'b1011, 2'b00});
      end
`endif
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      logic r, c, v, d, y;
      for (int n = 0; n < 600; n++) begin
         r = ($urandom_range(99, 0) < 1);
         c = ($urandom_range(99, 0) < 3);
         v = ($urandom_range(99, 0) < 70);
         d = 1'($urandom);
         y = ($urandom_range(99, 0) < 55);
         step(r, c, v, d, y);
         n_tests++;
         if (obs() !== expv()) begin
            n_fail++; $display("FAIL random_cycle%0d got=%h want=%h", n, obs(), expv());
         end
      end
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      reset = 1'b1; clear = 1'b0; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
      test_reset();
      test_bit_order();
      test_overflow();
      test_clear_reset();
      test_back_to_back();
      test_parity();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
